// File: rtl/audio_deserializer.sv
// -----------------------------------------------------------------------------
// audio_deserializer
//
// Receive side of the serial audio link. Bits arrive on serial_data and are
// qualified by a one-clock serial_valid strobe per bit. The block shifts them
// into a WIDTH-bit register and presents each finished word on a
// valid/ready output register for the sample buffer or playback path.
//
// Parameters:
//   WIDTH     : word length in bits (2..32)
//   MSB_FIRST : 1 = first received bit ends in data_out[WIDTH-1]
//               0 = first received bit ends in data_out[0]
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   enable        in   receive enable; low discards any partial word
//   serial_data   in   serial bit, sampled when serial_valid=1
//   serial_valid  in   bit strobe, one clock per bit
//   data_ready    in   downstream takes data_out this cycle
//   clear_overrun in   synchronous clear of the sticky overrun flag
//   data_out      out  assembled word, stable while data_valid=1
//   data_valid    out  data_out holds an unconsumed word
//   overrun       out  sticky: a completed word was dropped
//   bit_count     out  bits received in the current frame
//   busy          out  bit_count != 0
//   parity_error  out  delivered word failed even parity (0 without parity)
//
// Build option:
//   DESER_PARITY_EN : each frame carries one trailing even-parity bit after
//                     the WIDTH data bits; parity_error reports mismatches.
// -----------------------------------------------------------------------------
module audio_deserializer #(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       serial_data,
  input  logic                       serial_valid,
  input  logic                       data_ready,
  input  logic                       clear_overrun,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       busy,
  output logic                       parity_error
);

  localparam int CW = $clog2(WIDTH+1);
`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  // bit_count value at which the next sampled bit closes the frame
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_done;
  logic             complete;
  logic             accept;

`ifdef DESER_PARITY_EN
  logic perr_q, perr_d;
  logic perr_new;
`endif

  // The frame closes on the edge that samples its final bit.
  assign complete = enable && serial_valid && (cnt_q == LAST);
  // A finished word is taken when the output register is empty or being
  // emptied on this same edge.
  assign accept   = !valid_q || data_ready;

  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {shreg_q[WIDTH-2:0], serial_data};
    end else begin
      shifted = {serial_data, shreg_q[WIDTH-1:1]};
    end
  end

`ifdef DESER_PARITY_EN
  // The last bit of the frame is the parity bit: the data word is already
  // complete in the shift register and the parity bit is not shifted in.
  assign word_done = shreg_q;
  assign perr_new  = (^shreg_q) ^ serial_data;
`else
  assign word_done = shifted;
`endif

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef DESER_PARITY_EN
    perr_d  = perr_q;
`endif

    // Frame assembly
    if (!enable) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (serial_valid) begin
      if (complete) begin
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CW'(1);
      end
    end

    // Output register and handshake
    if (complete && accept) begin
      dout_d  = word_done;
      valid_d = 1'b1;
`ifdef DESER_PARITY_EN
      perr_d  = perr_new;
`endif
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
`ifdef DESER_PARITY_EN
      perr_d  = 1'b0;
`endif
    end

    // Sticky overrun; a new drop beats a simultaneous clear.
    if (complete && !accept) begin
      ovr_d = 1'b1;
    end else if (clear_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_count  = cnt_q;
  assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_audio_deserializer.sv
// -----------------------------------------------------------------------------
// tb_audio_deserializer
//
// Two instances share all inputs: one MSB-first, one LSB-first. Every frame
// pushes the expected word for each instance onto a scoreboard queue; the
// queues are popped and compared when the frame's final strobe has been
// sampled.
// -----------------------------------------------------------------------------
module tb_audio_deserializer;

  localparam int W = 16;
`ifdef DESER_PARITY_EN
  localparam int FRAME  = W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FRAME  = W;
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] w;
    logic         pe;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic serial_data = 1'b0;
  logic serial_valid = 1'b0;
  logic data_ready = 1'b0;
  logic clear_overrun = 1'b0;

  logic [W-1:0] do_m, do_l;
  logic         dv_m, dv_l, ov_m, ov_l, busy_m, busy_l, pe_m, pe_l;
  logic [4:0]   bc_m, bc_l;

  exp_t qm[$];
  exp_t ql[$];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  audio_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clock(clock), .reset(reset), .enable(enable),
    .serial_data(serial_data), .serial_valid(serial_valid),
    .data_ready(data_ready), .clear_overrun(clear_overrun),
    .data_out(do_m), .data_valid(dv_m), .overrun(ov_m),
    .bit_count(bc_m), .busy(busy_m), .parity_error(pe_m)
  );

  audio_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clock(clock), .reset(reset), .enable(enable),
    .serial_data(serial_data), .serial_valid(serial_valid),
    .data_ready(data_ready), .clear_overrun(clear_overrun),
    .data_out(do_l), .data_valid(dv_l), .overrun(ov_l),
    .bit_count(bc_l), .busy(busy_l), .parity_error(pe_l)
  );

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Serializer stand-in: word goes out MSB first in time, one strobe per
  // bit, each strobe preceded by gap idle clocks, then the parity bit when
  // the frame carries one (inject flips it).
  task automatic send_frame(input logic [W-1:0] word, input logic inject,
                            input int gap, input bit ready_on_last,
                            input bit push);
    exp_t e;
    logic b;
    if (push) begin
      e.w = word;       e.pe = PAR_EN ? inject : 1'b0; qm.push_back(e);
      e.w = rev(word);  ql.push_back(e);
    end
    for (int i = 0; i < FRAME; i++) begin
      b = (i < W) ? word[W-1-i] : ((^word) ^ inject);
      repeat (gap) tick();
      if (ready_on_last && i == FRAME-1) data_ready = 1'b1;
      serial_data  = b;
      serial_valid = 1'b1;
      tick();
      serial_valid = 1'b0;
      serial_data  = 1'b0;
      if (ready_on_last && i == FRAME-1) data_ready = 1'b0;
    end
  endtask

  task automatic send_partial(input logic [W-1:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      serial_data  = word[W-1-i];
      serial_valid = 1'b1;
      tick();
      serial_valid = 1'b0;
      serial_data  = 1'b0;
    end
  endtask

  task automatic pop_exp(output exp_t em, output exp_t el);
    em.w = 'x; em.pe = 1'bx;
    el.w = 'x; el.pe = 1'bx;
    if (qm.size() != 0) em = qm.pop_front();
    if (ql.size() != 0) el = ql.pop_front();
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) tick();
    total++;
    if ({dv_m, do_m, ov_m, bc_m, busy_m, pe_m, dv_l, do_l, ov_l, bc_l, busy_l, pe_l} !== '0) begin
      bad++;
      $display("FAIL reset_state: msb v=%b d=%h o=%b c=%0d b=%b p=%b lsb v=%b d=%h o=%b c=%0d b=%b p=%b, want all zero",
               dv_m, do_m, ov_m, bc_m, busy_m, pe_m, dv_l, do_l, ov_l, bc_l, busy_l, pe_l);
    end
    reset = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic test_msb_first();
    exp_t em, el;
    data_ready = 1'b0;
    send_frame(16'h8001, 1'b0, 3, 1'b0, 1'b1);
    pop_exp(em, el);
    total++;
    if ({dv_m, do_m, pe_m, dv_l, do_l, pe_l} !== {1'b1, em.w, em.pe, 1'b1, el.w, el.pe}) begin
      bad++;
      $display("FAIL word_8001: msb v=%b d=%h p=%b lsb v=%b d=%h p=%b, want v=1 d=%h p=%b / v=1 d=%h p=%b",
               dv_m, do_m, pe_m, dv_l, do_l, pe_l, em.w, em.pe, el.w, el.pe);
    end
    total++;
    if ({ov_m, ov_l, bc_m, bc_l, busy_m, busy_l} !== '0) begin
      bad++;
      $display("FAIL after_8001: ov=%b/%b cnt=%0d/%0d busy=%b/%b, want all zero",
               ov_m, ov_l, bc_m, bc_l, busy_m, busy_l);
    end
    consume();
    total++;
    if ({dv_m, dv_l} !== 2'b00) begin
      bad++;
      $display("FAIL consume_8001: valid=%b/%b, want 0/0", dv_m, dv_l);
    end
  endtask

  task automatic test_lsb_first();
    exp_t em, el;
    send_frame(16'h00FF, 1'b0, 1, 1'b0, 1'b1);
    pop_exp(em, el);
    total++;
    if ({dv_m, do_m, dv_l, do_l} !== {1'b1, em.w, 1'b1, el.w} || el.w !== 16'hFF00) begin
      bad++;
      $display("FAIL word_00ff: msb v=%b d=%h lsb v=%b d=%h, want v=1 d=%h / v=1 d=FF00",
               dv_m, do_m, dv_l, do_l, em.w);
    end
    consume();
  endtask

  task automatic test_loopback();
    exp_t em, el;
    data_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(16'hA5C3, 1'b0, 0, 1'b0, 1'b1);
      pop_exp(em, el);
      total++;
      if ({dv_m, do_m, dv_l, do_l} !== {1'b1, em.w, 1'b1, el.w}) begin
        bad++;
        $display("FAIL loopback_%0d: msb v=%b d=%h lsb v=%b d=%h, want d=%h / d=%h",
                 f, dv_m, do_m, dv_l, do_l, em.w, el.w);
      end
    end
    tick();
    data_ready = 1'b0;
    total++;
    if ({dv_m, dv_l, ov_m, ov_l} !== 4'b0000) begin
      bad++;
      $display("FAIL loopback_end: valid=%b/%b ov=%b/%b, want 0/0 0/0", dv_m, dv_l, ov_m, ov_l);
    end
  endtask

  task automatic test_overrun();
    exp_t em, el;
    data_ready = 1'b0;
    send_frame(16'h1234, 1'b0, 1, 1'b0, 1'b1);
    pop_exp(em, el);
    total++;
    if ({dv_m, do_m, dv_l, do_l} !== {1'b1, em.w, 1'b1, el.w}) begin
      bad++;
      $display("FAIL word_1234: msb d=%h lsb d=%h, want %h / %h", do_m, do_l, em.w, el.w);
    end
    send_frame(16'h5678, 1'b0, 1, 1'b0, 1'b0);
    total++;
    if ({dv_m, do_m, ov_m, dv_l, do_l, ov_l} !== {1'b1, em.w, 1'b1, 1'b1, el.w, 1'b1}) begin
      bad++;
      $display("FAIL overrun_drop: msb d=%h ov=%b lsb d=%h ov=%b, want %h ov=1 / %h ov=1",
               do_m, ov_m, do_l, ov_l, em.w, el.w);
    end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    total++;
    if ({ov_m, ov_l, dv_m, dv_l} !== 4'b0011) begin
      bad++;
      $display("FAIL overrun_clear: ov=%b/%b valid=%b/%b, want 0/0 1/1", ov_m, ov_l, dv_m, dv_l);
    end
    send_frame(16'h9ABC, 1'b0, 1, 1'b1, 1'b1);
    pop_exp(em, el);
    total++;
    if ({dv_m, do_m, ov_m, dv_l, do_l, ov_l} !== {1'b1, em.w, 1'b0, 1'b1, el.w, 1'b0}) begin
      bad++;
      $display("FAIL same_edge_9abc: msb v=%b d=%h ov=%b lsb v=%b d=%h ov=%b, want v=1 d=%h ov=0 / d=%h",
               dv_m, do_m, ov_m, dv_l, do_l, ov_l, em.w, el.w);
    end
    consume();
  endtask

  task automatic test_abort();
    exp_t em, el;
    send_partial(16'hAAAA, 7);
    total++;
    if ({bc_m, busy_m, bc_l, busy_l} !== {5'd7, 1'b1, 5'd7, 1'b1}) begin
      bad++;
      $display("FAIL partial_7: cnt=%0d/%0d busy=%b/%b, want 7/7 1/1", bc_m, bc_l, busy_m, busy_l);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    total++;
    if ({bc_m, busy_m, bc_l, busy_l} !== '0) begin
      bad++;
      $display("FAIL abort: cnt=%0d/%0d busy=%b/%b, want 0/0 0/0", bc_m, bc_l, busy_m, busy_l);
    end
    send_frame(16'hFFFF, 1'b0, 0, 1'b0, 1'b1);
    pop_exp(em, el);
    total++;
    if ({dv_m, do_m, dv_l, do_l} !== {1'b1, em.w, 1'b1, el.w}) begin
      bad++;
      $display("FAIL word_ffff: msb v=%b d=%h lsb v=%b d=%h, want d=%h / d=%h",
               dv_m, do_m, dv_l, do_l, em.w, el.w);
    end
  endtask

  task automatic test_reset_midframe();
    send_partial(16'h5555, 9);
    total++;
    if ({bc_m, bc_l, dv_m, dv_l} !== {5'd9, 5'd9, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL midframe_9: cnt=%0d/%0d valid=%b/%b, want 9/9 1/1", bc_m, bc_l, dv_m, dv_l);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({dv_m, do_m, ov_m, bc_m, busy_m, pe_m, dv_l, do_l, ov_l, bc_l, busy_l, pe_l} !== '0) begin
      bad++;
      $display("FAIL async_reset: msb v=%b d=%h c=%0d b=%b lsb v=%b d=%h c=%0d b=%b, want all zero",
               dv_m, do_m, bc_m, busy_m, dv_l, do_l, bc_l, busy_l);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    exp_t em, el;
    send_frame(16'h0001, 1'b0, 1, 1'b0, 1'b1);
    pop_exp(em, el);
    total++;
    if ({dv_m, do_m, pe_m, dv_l, do_l, pe_l} !== {1'b1, em.w, em.pe, 1'b1, el.w, el.pe}) begin
      bad++;
      $display("FAIL parity_good: msb d=%h p=%b lsb d=%h p=%b, want %h p=%b", do_m, pe_m, do_l, pe_l, em.w, em.pe);
    end
    consume();
    send_frame(16'h0001, 1'b1, 1, 1'b0, 1'b1);
    pop_exp(em, el);
    total++;
    if ({dv_m, do_m, pe_m, dv_l, do_l, pe_l} !== {1'b1, em.w, em.pe, 1'b1, el.w, el.pe}) begin
      bad++;
      $display("FAIL parity_bad: msb d=%h p=%b lsb d=%h p=%b, want %h p=%b", do_m, pe_m, do_l, pe_l, em.w, em.pe);
    end
    consume();
    total++;
    if ({pe_m, pe_l, dv_m, dv_l} !== 4'b0000) begin
      bad++;
      $display("FAIL parity_clear: perr=%b/%b valid=%b/%b, want 0/0 0/0", pe_m, pe_l, dv_m, dv_l);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_loopback();
    test_overrun();
    test_abort();
    test_reset_midframe();
    enable = 1'b1;
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
